// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store onto one byte-wide port.
// Optional macro MEM_CTRL_RR_ARB_EN selects round-robin arbitration instead of fixed load/store priority.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        clear,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state;
    logic [1:0]  k;
    logic [1:0]  n;          // byte total modulo 4: a word is stored as 0
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] buf_q;
    logic        if_done_q;
    logic        ls_done_q;

    logic        idle_free;
    logic        if_ok;
    logic        pick_ls;
    logic        grant_ls;
    logic        grant_if;
    logic        grant_stall;
    logic        wr_stall;
    logic        last_wr;
    logic [1:0]  req_n;
    logic [1:0]  k_prev;
    logic [31:0] cur_addr;
    logic [31:0] prev_addr;
    logic [7:0]  wdata_byte;
    logic [31:0] buf_next;

    assign idle_free = (state == IDLE) && rdy_in && !rst_in && !if_done_q && !ls_done_q;
    assign if_ok     = if_req && !clear;

`ifdef MEM_CTRL_RR_ARB_EN
    logic last_ls;
    assign pick_ls = ls_req && (!if_ok || !last_ls);
`else
    assign pick_ls = ls_req;
`endif

    assign grant_ls    = idle_free && pick_ls;
    assign grant_if    = idle_free && if_ok && !pick_ls;
    assign grant_stall = ls_we && (ls_addr[17:16] == IO_HI) && io_buffer_full;

    assign k_prev     = k - 2'd1;
    assign cur_addr   = addr + {30'd0, k};
    assign prev_addr  = addr + {30'd0, k_prev};
    assign wr_stall   = (cur_addr[17:16] == IO_HI) && io_buffer_full;
    assign last_wr    = (k == n - 2'd1);
    assign wdata_byte = wdata[{k, 3'b000} +: 8];

    always_comb begin
        case (ls_size)
            2'd0:    req_n = 2'd1;
            2'd1:    req_n = 2'd2;
            default: req_n = 2'd0;
        endcase
    end

    // Read data arrives one cycle after its address, so cycle k fills lane k-1.
    always_comb begin
        buf_next = buf_q;
        buf_next[{k_prev, 3'b000} +: 8] = mem_din;
    end

    // While frozen, a read keeps presenting the byte it will capture on resume,
    // so mem_din is valid for that byte when rdy_in returns.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ls) begin
                    if (!ls_we) begin
                        mem_a = ls_addr;
                    end else if (!grant_stall) begin
                        mem_a    = ls_addr;
                        mem_dout = ls_wdata[7:0];
                        mem_wr   = 1'b1;
                    end
                end else if (grant_if) begin
                    mem_a = if_addr;
                end
            end
            IF_RD, LS_RD: begin
                if (!rdy_in)
                    mem_a = prev_addr;
                else if (k != n)
                    mem_a = cur_addr;
            end
            LS_WR: begin
                if (rdy_in && !wr_stall) begin
                    mem_a    = cur_addr;
                    mem_dout = wdata_byte;
                    mem_wr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign if_done   = if_done_q && rdy_in;
    assign ls_done   = ls_done_q && rdy_in;
    assign dbg_state = state;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            k         <= 2'd0;
            n         <= 2'd0;
            addr      <= '0;
            wdata     <= '0;
            buf_q     <= '0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            if_data   <= '0;
            ls_rdata  <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
            last_ls   <= 1'b0;
`endif
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        addr  <= ls_addr;
                        wdata <= ls_wdata;
                        n     <= req_n;
                        buf_q <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
                        last_ls <= 1'b1;
`endif
                        if (!ls_we) begin
                            state <= LS_RD;
                            k     <= 2'd1;
                        end else if (grant_stall) begin
                            state <= LS_WR;
                            k     <= 2'd0;
                        end else if (req_n == 2'd1) begin
                            ls_done_q <= 1'b1;
                        end else begin
                            state <= LS_WR;
                            k     <= 2'd1;
                        end
                    end else if (grant_if) begin
                        addr  <= if_addr;
                        n     <= 2'd0;
                        buf_q <= '0;
                        state <= IF_RD;
                        k     <= 2'd1;
`ifdef MEM_CTRL_RR_ARB_EN
                        last_ls <= 1'b0;
`endif
                    end
                end
                IF_RD, LS_RD: begin
                    if (state == IF_RD && clear) begin
                        state <= IDLE;
                        k     <= 2'd0;
                    end else begin
                        buf_q <= buf_next;
                        if (k == n) begin
                            state <= IDLE;
                            k     <= 2'd0;
                            if (state == IF_RD) begin
                                if_data   <= buf_next;
                                if_done_q <= 1'b1;
                            end else begin
                                ls_rdata  <= buf_next;
                                ls_done_q <= 1'b1;
                            end
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                LS_WR: begin
                    if (!wr_stall) begin
                        if (last_wr) begin
                            state     <= IDLE;
                            k         <= 2'd0;
                            ls_done_q <= 1'b1;
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single transactions plus hand-written
// sequences for arbitration, I/O stall, flush, freeze and mid-operation reset.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        clear;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .clear(clear), .dbg_state(dbg_state)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory model: fixed background pattern, overlaid by anything written.
    logic [7:0] wmem [logic [31:0]];

    function automatic logic [7:0] base_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            default:  return a[7:0] ^ a[15:8];
        endcase
    endfunction

    always @(posedge clk_in) begin
        mem_din <= wmem.exists(mem_a) ? wmem[mem_a] : base_byte(mem_a);
        if (mem_wr) begin
            wmem[mem_a] = mem_dout;
            wr_count    = wr_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          done_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int n;
        int done_at;
        n = (!v.is_ls || v.size == 2'd2) ? 4 : (v.size == 2'd1 ? 2 : 1);
        done_at = -1;
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_size = v.size; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (c < n) begin
                check("vec_addr", mem_a, v.addr + c);
                check("vec_wr", {31'd0, mem_wr}, {31'd0, v.we});
                if (v.we) check("vec_dout", {24'd0, mem_dout}, (v.wdata >> (8 * c)) & 32'hff);
            end
            if (v.is_ls ? ls_done : if_done) begin
                done_at = c;
                check("vec_idle_a", mem_a, 32'h0);
                break;
            end
            next_cycle();
        end
        check("vec_done_cycle", done_at, v.done_cyc);
        if (!v.we && done_at >= 0) check("vec_data", v.is_ls ? ls_rdata : if_data, v.exp);
        next_cycle();
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    initial begin
        int ls_done_at;
        int if_done_at;
        int if_grant_at;
        int seen_if;
        int wr_start;
        int late_done;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 2'd2, 32'h0, 32'h0000_0513, 5};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2002, 2'd0, 32'h0, 32'h0000_0022, 2};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2002, 2'd1, 32'h0, 32'h0000_2322, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_4010, 2'd2, 32'h0, 32'h5352_5150, 5};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_5000, 2'd2, 32'hDEAD_BEEF, 32'h0, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_500A, 2'd1, 32'h0000_1234, 32'h0, 2};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_6000, 2'd0, 32'h0000_0077, 32'h0, 1};
        vecs[7] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, 32'h0100_0001, 5};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_5000, 2'd2, 32'h0, 32'hDEAD_BEEF, 5};

        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
        @(negedge clk_in);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        check("rst_dones", {30'd0, if_done, ls_done}, 32'h0);
        check("rst_data", if_data | ls_rdata, 32'h0);
        check("rst_state", {30'd0, dbg_state}, 32'h0);
        next_cycle();
        if_req = 1'b0;
        rst_in = 1'b0;
        next_cycle();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous requests: load/store first, fetch granted after its done.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2002; ls_size = 2'd0;
        if_req = 1'b1; if_addr = 32'h1000;
        ls_done_at = -1; if_done_at = -1; if_grant_at = -1;
        for (int c = 0; c < 16; c++) begin
            if (ls_done_at >= 0 && c == ls_done_at + 1) ls_req = 1'b0;
            if (if_done_at >= 0 && c == if_done_at + 1) if_req = 1'b0;
            @(negedge clk_in);
            if (c == 0) check("arb_first_addr", mem_a, 32'h2002);
            if (ls_done && ls_done_at < 0) ls_done_at = c;
            if (if_done && if_done_at < 0) if_done_at = c;
            if (mem_a == 32'h1000 && if_grant_at < 0) if_grant_at = c;
            next_cycle();
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("arb_ls_done", ls_done_at, 2);
        check("arb_if_grant", if_grant_at, 3);
        check("arb_if_done", if_done_at, 8);
        check("arb_if_data", if_data, 32'h0000_0513);

        // I/O write held while the UART buffer is full.
        wr_start = wr_count;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wdata = 32'h41;
        io_buffer_full = 1'b1;
        ls_done_at = -1;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) io_buffer_full = 1'b0;
            if (ls_done_at >= 0 && c == ls_done_at + 1) ls_req = 1'b0;
            @(negedge clk_in);
            if (c < 3) begin
                check("io_stall_wr", {31'd0, mem_wr}, 32'h0);
                check("io_stall_a", mem_a, 32'h0);
            end
            if (c == 3) begin
                check("io_write_wr", {31'd0, mem_wr}, 32'h1);
                check("io_write_a", mem_a, 32'h0003_0000);
                check("io_write_dout", {24'd0, mem_dout}, 32'h41);
            end
            if (ls_done && ls_done_at < 0) ls_done_at = c;
            next_cycle();
        end
        ls_req = 1'b0; ls_we = 1'b0;
        check("io_done", ls_done_at, 4);
        check("io_write_count", wr_count - wr_start, 1);

        // Flush during a fetch; the following cycle accepts a new request.
        if_req = 1'b1; if_addr = 32'h1000;
        seen_if = 0; ls_done_at = -1;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) clear = 1'b1;
            if (c == 3) begin
                clear = 1'b0; if_req = 1'b0;
                ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2002; ls_size = 2'd0;
            end
            if (ls_done_at >= 0 && c == ls_done_at + 1) ls_req = 1'b0;
            @(negedge clk_in);
            if (if_done) seen_if = 1;
            if (c == 3) begin
                check("clr_state_idle", {30'd0, dbg_state}, 32'h0);
                check("clr_new_grant", mem_a, 32'h2002);
            end
            if (ls_done && ls_done_at < 0) ls_done_at = c;
            next_cycle();
        end
        ls_req = 1'b0;
        check("clr_no_if_done", seen_if, 0);
        check("clr_ls_done", ls_done_at, 5);

        // Flush in idle blocks a same-cycle fetch grant.
        if_req = 1'b1; if_addr = 32'h1000; clear = 1'b1;
        @(negedge clk_in);
        check("clr_idle_a", mem_a, 32'h0);
        next_cycle();
        if_req = 1'b0; clear = 1'b0;
        @(negedge clk_in);
        check("clr_idle_state", {30'd0, dbg_state}, 32'h0);
        next_cycle();

        // Freeze for two cycles inside a half-word load.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2002; ls_size = 2'd1;
        ls_done_at = -1;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) rdy_in = 1'b0;
            if (c == 3) rdy_in = 1'b1;
            if (ls_done_at >= 0 && c == ls_done_at + 1) ls_req = 1'b0;
            @(negedge clk_in);
            if (c == 1 || c == 2) begin
                check("frz_wr", {31'd0, mem_wr}, 32'h0);
                check("frz_done", {31'd0, ls_done}, 32'h0);
            end
            if (ls_done && ls_done_at < 0) begin
                ls_done_at = c;
                check("frz_data", ls_rdata, 32'h0000_2322);
            end
            next_cycle();
        end
        ls_req = 1'b0;
        check("frz_done_cycle", ls_done_at, 5);

        // Reset in the middle of a word store.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h7000; ls_size = 2'd2; ls_wdata = 32'hCAFE_BABE;
        next_cycle();
        next_cycle();
        rst_in = 1'b1;
        #1;
        check("mid_rst_wr", {31'd0, mem_wr}, 32'h0);
        check("mid_rst_a", mem_a, 32'h0);
        check("mid_rst_dout", {24'd0, mem_dout}, 32'h0);
        check("mid_rst_data", if_data | ls_rdata, 32'h0);
        ls_req = 1'b0; ls_we = 1'b0;
        next_cycle();
        rst_in = 1'b0;
        late_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            if (ls_done || if_done) late_done = 1;
            next_cycle();
        end
        check("mid_rst_no_done", late_done, 0);
        check("mid_rst_state", {30'd0, dbg_state}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
